// File: rtl/max7219_pkg.sv
// Shared constants, FSM state type and frame layout for the MAX7219 serial transmitter.
// No logic of its own; the init ROM lives here as a pure function.
// Imported by the top, the shifter and the bench.
package max7219_pkg;

   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIMIT = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   localparam int INIT_WORDS = 5;

   typedef enum logic [1:0] {
      INIT_LOAD,
      SHIFT,
      GAP_ST,
      IDLE
   } state_t;

   // One 16-bit MAX7219 register write, transmitted MSB first.
   typedef struct packed {
      logic [3:0] pad;
      logic [3:0] addr;
      logic [7:0] data;
   } frame_t;

   // Init ROM: display test off, no decode, scan all 8 digits, intensity, leave shutdown.
   function automatic frame_t init_word(input logic [2:0] k, input logic [3:0] intensity);
      frame_t f;
      f.pad = 4'h0;
      case (k)
         3'd0:    begin f.addr = REG_TEST;      f.data = 8'h00;               end
         3'd1:    begin f.addr = REG_DECODE;    f.data = 8'h00;               end
         3'd2:    begin f.addr = REG_SCANLIMIT; f.data = 8'h07;               end
         3'd3:    begin f.addr = REG_INTENSITY; f.data = {4'h0, intensity};   end
         default: begin f.addr = REG_SHUTDOWN;  f.data = 8'h01;               end
      endcase
      return f;
   endfunction

endpackage

// File: rtl/max7219_tx_if.sv
// Column-byte stream from the glyph provider: one (row, byte) per valid/ready handshake.
// Pure wiring, no latency.
// Producer holds col_row/col_data stable while col_valid is high and col_ready is low.
interface max7219_tx_if;
   logic [7:0] col_data;
   logic [2:0] col_row;
   logic       col_valid;
   logic       col_ready;

   modport master (output col_data, col_row, col_valid, input col_ready);
   modport slave  (input col_data, col_row, col_valid, output col_ready);
endinterface

// File: rtl/max7219_shifter.sv
// Serialises one 16-bit frame MSB first with a CLK_DIV-cycle low and high phase per bit.
// Latency: max_din valid the cycle after start; done pulses in cycle 32*CLK_DIV after start.
// No backpressure: start is only issued by the owner while the shifter is idle.
module max7219_shifter
   import max7219_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  frame_t word,
   output logic   max_din,
   output logic   max_clk,
   output logic   done
);

   localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

   logic [15:0]     sreg;
   logic [3:0]      bit_cnt;
   logic [PH_W-1:0] ph_cnt;
   logic            active;

   // The current bit always sits in sreg[15]; it only moves when max_clk falls.
   assign max_din = sreg[15];
   assign done    = active && max_clk && (ph_cnt == PH_LAST) && (bit_cnt == 4'd0);

   // Phase generator and shift register: low phase then high phase per bit, 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg    <= '0;
         bit_cnt <= '0;
         ph_cnt  <= '0;
         active  <= 1'b0;
         max_clk <= 1'b0;
      end else if (start) begin
         sreg    <= word;
         bit_cnt <= 4'd15;
         ph_cnt  <= '0;
         active  <= 1'b1;
         max_clk <= 1'b0;
      end else if (active) begin
         if (ph_cnt != PH_LAST) begin
            ph_cnt <= ph_cnt + 1'b1;
         end else begin
            ph_cnt <= '0;
            if (!max_clk) begin
               max_clk <= 1'b1;
            end else begin
               max_clk <= 1'b0;
               if (bit_cnt == 4'd0) begin
                  active <= 1'b0;
                  sreg   <= '0;
               end else begin
                  bit_cnt <= bit_cnt - 4'd1;
                  sreg    <= {sreg[14:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/max7219_tx.sv
// MAX7219 driver: sends the 5-word init sequence after reset, then one digit write per accepted byte.
// Latency: frame starts (max_cs low) the cycle after acceptance; one byte every 1+32*CLK_DIV+GAP cycles.
// col_ready is high only in IDLE after init; a held col_valid waits until the current frame finishes.
module max7219_tx
   import max7219_pkg::*;
#(
   parameter int         CLK_DIV   = 4,
   parameter int         GAP       = 2,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic        clk,
   input  logic        rst,
   max7219_tx_if.slave col,
   output logic        max_din,
   output logic        max_clk,
   output logic        max_cs,
   output logic        init_done,
   output logic        busy
);

   localparam int              GAP_W    = $clog2(GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
   localparam logic [2:0]       K_LAST   = 3'(INIT_WORDS - 1);

   state_t           state;
   logic [2:0]       init_k;
   logic [GAP_W-1:0] gap_cnt;
   logic             ready_q;
   logic             hs;
   logic             sh_start;
   logic             sh_done;
   frame_t           sh_word;

   assign col.col_ready = ready_q;

   // Frame source: init ROM while initialising, otherwise the byte being accepted right now.
   always_comb begin
      hs       = 1'b0;
      sh_start = 1'b0;
      sh_word  = init_word(init_k, INTENSITY);
      if (state == IDLE) begin
         hs           = col.col_valid && ready_q;
         sh_word.pad  = 4'h0;
         sh_word.addr = REG_DIGIT0 + {1'b0, col.col_row};
         sh_word.data = col.col_data;
      end
      sh_start = (state == INIT_LOAD) || hs;
   end

   max7219_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (sh_start),
      .word    (sh_word),
      .max_din (max_din),
      .max_clk (max_clk),
      .done    (sh_done)
   );

   // Frame sequencer: init words, inter-frame gap, handshake and LOAD/CS framing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_LOAD;
         init_k    <= '0;
         gap_cnt   <= '0;
         max_cs    <= 1'b1;
         ready_q   <= 1'b0;
         init_done <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            INIT_LOAD: begin
               state  <= SHIFT;
               max_cs <= 1'b0;
            end
            SHIFT: begin
               // Rising LOAD on the last high-phase edge latches the word in the MAX7219.
               if (sh_done) begin
                  state   <= GAP_ST;
                  max_cs  <= 1'b1;
                  gap_cnt <= '0;
               end
            end
            GAP_ST: begin
               if (gap_cnt == GAP_LAST) begin
                  if (init_done || (init_k == K_LAST)) begin
                     state     <= IDLE;
                     init_done <= 1'b1;
                     ready_q   <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state  <= INIT_LOAD;
                     init_k <= init_k + 3'd1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (hs) begin
                  state   <= SHIFT;
                  max_cs  <= 1'b0;
                  ready_q <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            default: begin
               state <= INIT_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_tx.sv
// Directed bench for max7219_tx: serial-side monitor rebuilds each latched 16-bit word.
// Expected words, frame lengths and handshake spacing are hand-computed constants.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_max7219_tx;

   localparam int         CLK_DIV   = 2;
   localparam int         GAP       = 2;
   localparam logic [3:0] INTENSITY = 4'h8;
   localparam int         CS_LOW    = 64;   // 32*CLK_DIV
   localparam int         FRAME_CYC = 67;   // 1 + 32*CLK_DIV + GAP

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic max_din, max_clk, max_cs, init_done, busy;

   max7219_tx_if col_if ();

   max7219_tx #(
      .CLK_DIV   (CLK_DIV),
      .GAP       (GAP),
      .INTENSITY (INTENSITY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col_if),
      .max_din   (max_din),
      .max_clk   (max_clk),
      .max_cs    (max_cs),
      .init_done (init_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [15:0] init_exp [5] = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};
   logic [15:0] strm_exp [8] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408,
                                 16'h0510, 16'h0620, 16'h0740, 16'h0880};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Serial monitor: shift DIN on max_clk rise while CS low, emit word on CS rise after 16 bits.
   logic [15:0] mon_sh = '0;
   int          mon_bits = 0;
   int          mon_low = 0;
   int          tog_err = 0;
   bit          tog_en = 1'b0;
   logic        p_cs = 1'b1, p_clk = 1'b0, p_din = 1'b0;
   logic [15:0] wq [$];
   int          lq [$];

   always @(negedge clk) begin
      if (p_cs === 1'b1 && max_cs === 1'b0) begin
         mon_bits = 0;
         mon_low  = 0;
      end
      if (max_cs === 1'b0) mon_low++;
      if (max_cs === 1'b0 && p_clk === 1'b0 && max_clk === 1'b1) begin
         mon_sh = {mon_sh[14:0], max_din};
         mon_bits++;
      end
      if (p_cs === 1'b0 && max_cs === 1'b1 && mon_bits == 16) begin
         wq.push_back(mon_sh);
         lq.push_back(mon_low);
      end
      if (tog_en && (max_din !== p_din) &&
          !((p_clk === 1'b1 && max_clk === 1'b0) || (p_cs === 1'b1 && max_cs === 1'b0)))
         tog_err++;
      p_cs  = max_cs;
      p_clk = max_clk;
      p_din = max_din;
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (col_if.col_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (col_if.col_ready !== 1'b1) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic pop_word(input string tag, input logic [15:0] exp_w);
      int n = 0;
      while (wq.size() == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (wq.size() == 0) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         check(tag, wq.pop_front(), exp_w);
         check({tag, "_cslow"}, lq.pop_front(), CS_LOW);
      end
   endtask

   initial begin
      int hs_cyc;
      int prev_hs;
      int early;
      int n;

      col_if.col_valid = 1'b0;
      col_if.col_row   = 3'd0;
      col_if.col_data  = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cs",    max_cs, 1);
      check("rst_clk",   max_clk, 0);
      check("rst_din",   max_din, 0);
      check("rst_ready", col_if.col_ready, 0);
      check("rst_done",  init_done, 0);
      check("rst_busy",  busy, 1);
      rst = 1'b0;
      @(negedge clk);
      check("first_frame_cs", max_cs, 0);
      tog_en = 1'b1;

      // Init sequence
      for (int k = 0; k < 5; k++) pop_word($sformatf("init%0d", k), init_exp[k]);
      wait_ready("init");
      check("init_done", init_done, 1);
      check("idle_busy", busy, 0);

      // Single byte; col_* changed mid-frame must not affect the word
      col_if.col_row   = 3'd3;
      col_if.col_data  = 8'hA5;
      col_if.col_valid = 1'b1;
      hs_cyc = cyc + 1;
      @(negedge clk);
      col_if.col_valid = 1'b0;
      check("hs_accept", {busy, col_if.col_ready, max_cs}, 3'b100);
      col_if.col_row  = 3'd6;
      col_if.col_data = 8'h5A;
      pop_word("word_04A5", 16'h04A5);
      wait_ready("ret");
      check("ready_return", cyc + 1 - hs_cyc, FRAME_CYC);

      // Held valid, rows 0..7
      prev_hs = 0;
      for (int i = 0; i < 8; i++) begin
         col_if.col_row   = i[2:0];
         col_if.col_data  = 8'(1 << i);
         col_if.col_valid = 1'b1;
         wait_ready("stream");
         if (i > 0) check($sformatf("spacing%0d", i), cyc + 1 - prev_hs, FRAME_CYC);
         prev_hs = cyc + 1;
         @(negedge clk);
      end
      col_if.col_valid = 1'b0;
      for (int i = 0; i < 8; i++) pop_word($sformatf("stream%0d", i), strm_exp[i]);
      check("din_toggle", tog_err, 0);
      tog_en = 1'b0;

      // Valid asserted across reset and init
      col_if.col_row   = 3'd5;
      col_if.col_data  = 8'h3C;
      col_if.col_valid = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      early = 0;
      n = 0;
      while (init_done !== 1'b1 && n < 2000) begin
         if (col_if.col_ready !== 1'b0) early++;
         @(negedge clk);
         n++;
      end
      check("ready_before_init", early, 0);
      check("init_done2", init_done, 1);
      @(negedge clk);
      col_if.col_valid = 1'b0;
      for (int k = 0; k < 5; k++) pop_word($sformatf("reinit%0d", k), init_exp[k]);
      pop_word("after_init", 16'h063C);

      // Reset during bit 7 of a data frame
      wait_ready("pre_abort");
      col_if.col_row   = 3'd0;
      col_if.col_data  = 8'hFF;
      col_if.col_valid = 1'b1;
      @(negedge clk);
      col_if.col_valid = 1'b0;
      repeat (32) @(negedge clk);
      check("abort_in_frame", max_cs, 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_cs",    max_cs, 1);
      check("abort_clk",   max_clk, 0);
      check("abort_din",   max_din, 0);
      check("abort_done",  init_done, 0);
      check("abort_ready", col_if.col_ready, 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) pop_word($sformatf("abort_init%0d", k), init_exp[k]);
      wait_ready("abort_init");
      check("abort_no_word", wq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
